// File: rtl/line_stream_pkg.sv
// Shared types and beat-count helper for the cache-line word streamer.
package line_stream_pkg;

  typedef enum logic {IDLE, STREAM} lws_state_e;

  // Beats a request produces: len 0 or oversize means a full line; linear mode truncates at the last word.
  function automatic int unsigned eff_beats(input int unsigned len, input int unsigned off,
                                            input logic wrap, input int unsigned words);
    int unsigned e;
    e = (len == 0 || len > words) ? words : len;
    if (!wrap && e > words - off) e = words - off;
    return e;
  endfunction

endpackage

// File: rtl/line_word_sel.sv
// Combinational word select from a cache line; word 0 sits at the MSB end.
module line_word_sel #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 8,
  localparam int unsigned LINE_W = WORD_W * WORDS,
  localparam int unsigned OFF_W  = $clog2(WORDS)
) (
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == OFF_W'(i)) word = line[LINE_W-1-i*WORD_W -: WORD_W];
    end
  end

endmodule

// File: rtl/line_word_streamer.sv
// Streams selected words of a captured cache line, wrap or linear order, one per handshake.
// Build option: define LINE_WORD_STREAMER_BSWAP_EN to byte-reverse each output word.
module line_word_streamer
  import line_stream_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 8,
  localparam int unsigned LINE_W = WORD_W * WORDS,
  localparam int unsigned OFF_W  = $clog2(WORDS),
  localparam int unsigned LEN_W  = $clog2(WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LINE_W-1:0] req_line,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_wrap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [OFF_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  lws_state_e        state;
  logic [LINE_W-1:0] line_q;
  logic [OFF_W-1:0]  remain;
  logic [OFF_W-1:0]  beats_m1;
  logic [WORD_W-1:0] sel_word;
  logic              accept;
  logic              beat_done;

  assign out_last  = out_valid && (remain == '0);
  assign beat_done = out_valid && out_ready;
  assign req_ready = (state == IDLE) || (beat_done && out_last);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == STREAM);

  always_comb begin
    int unsigned beats;
    beats    = eff_beats(32'(req_len), 32'(req_offset), req_wrap, WORDS);
    beats_m1 = OFF_W'(beats - 1);
  end

  // A new accept takes priority so a request landing on the last beat streams with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      line_q    <= '0;
      out_idx   <= '0;
      remain    <= '0;
    end else if (accept) begin
      state     <= STREAM;
      out_valid <= 1'b1;
      line_q    <= req_line;
      out_idx   <= req_offset;
      remain    <= beats_m1;
    end else if (beat_done) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        out_idx <= out_idx + 1'b1;
        remain  <= remain - 1'b1;
      end
    end
  end

  line_word_sel #(.WORD_W(WORD_W), .WORDS(WORDS)) u_sel (
    .line (line_q),
    .idx  (out_idx),
    .word (sel_word)
  );

`ifdef LINE_WORD_STREAMER_BSWAP_EN
  always_comb begin
    out_data = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) begin
      out_data[b*8 +: 8] = sel_word[WORD_W-8-b*8 +: 8];
    end
  end
`else
  assign out_data = sel_word;
`endif

endmodule
